// File: rtl/melody_scheduler.sv
// Jingle sequencer/arbiter for the shared buzzer tone path.
// Plays start/score/gameover note tables with note and gap timing.
module melody_scheduler #(
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 2500000,
  parameter int CNT_W      = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic        mute,
  output logic [21:0] pitch,
  output logic        music,
  output logic        busy,
  output logic [2:0]  grant,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_e;

  localparam logic [21:0] DO  = 22'd191571;
  localparam logic [21:0] RE  = 22'd170648;
  localparam logic [21:0] MI  = 22'd151515;
  localparam logic [21:0] FA  = 22'd143266;
  localparam logic [21:0] SO  = 22'd127551;
  localparam logic [21:0] SI  = 22'd101215;
  localparam logic [21:0] HDO = 22'd95420;

  localparam bit HAS_GAP = (GAP_TICKS > 0);
  localparam logic [CNT_W-1:0] NOTE_RL = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_RL =
    CNT_W'(HAS_GAP ? GAP_TICKS - 1 : 0);

  function automatic logic [21:0] tone(
    input logic [2:0] g,
    input logic [2:0] i
  );
    logic [21:0] t;
    t = '0;
    unique case (1'b1)
      g[2]: begin
        case (i)
          3'd0:              t = SI;
          3'd1, 3'd2, 3'd3:  t = FA;
          3'd4:              t = MI;
          3'd5:              t = RE;
          default:           t = DO;
        endcase
      end
      g[1]: begin
        case (i)
          3'd0:    t = DO;
          3'd1:    t = MI;
          3'd2:    t = SO;
          default: t = HDO;
        endcase
      end
      default: begin
        case (i)
          3'd4:       t = DO;
          3'd6, 3'd7: t = SO;
          default:    t = MI;
        endcase
      end
    endcase
    return t;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       grant_q, grant_d;
  logic [21:0]      pitch_q, pitch_d;
  logic             music_q, music_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0] eff;
  logic [2:0] sel;
  logic [2:0] last;
  logic       start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    start   = 1'b0;
    sel     = 3'b000;
    // a request for the song already playing is dropped
    eff     = pend_q | (req & ~grant_q);
    pend_d  = eff;
    last    = grant_q[1] ? 3'd3 : 3'd7;
    case (state_q)
      IDLE: begin
        if (|eff) begin
          start = 1'b1;
          sel   = eff[2] ? 3'b100 : (eff[1] ? 3'b010 : 3'b001);
        end
      end
      NOTE, GAP: begin
        if (eff[2] && !grant_q[2]) begin
          start = 1'b1;
          sel   = 3'b100;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == NOTE && HAS_GAP) begin
          state_d = GAP;
          cnt_d   = GAP_RL;
        end else if (idx_q != last) begin
          state_d = NOTE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = NOTE_RL;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = NOTE;
      grant_d = sel;
      pend_d  = eff & ~sel;
      idx_d   = '0;
      cnt_d   = NOTE_RL;
    end
    pitch_d = (state_d == IDLE) ? '0 : tone(grant_d, idx_d);
    music_d = (state_d == NOTE) && !mute;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      pitch_q <= '0;
      music_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      pitch_q <= pitch_d;
      music_q <= music_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pitch = pitch_q;
  assign music = music_q;
  assign busy  = busy_q;
  assign grant = grant_q;
  assign done  = done_q;

endmodule

// File: tb/tb_melody_scheduler.sv
// Bench for melody_scheduler: gapped and legato instances
// checked against a time-based song model.
module tb_melody_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        mute;

  logic [21:0] pitch_a, pitch_b;
  logic        music_a, music_b;
  logic        busy_a, busy_b;
  logic [2:0]  grant_a, grant_b;
  logic        done_a, done_b;

  melody_scheduler #(.NOTE_TICKS(4), .GAP_TICKS(2), .CNT_W(4)) u_gap (
    .clk(clk), .rst(rst), .req(req), .mute(mute),
    .pitch(pitch_a), .music(music_a), .busy(busy_a),
    .grant(grant_a), .done(done_a)
  );

  melody_scheduler #(.NOTE_TICKS(4), .GAP_TICKS(0), .CNT_W(4)) u_leg (
    .clk(clk), .rst(rst), .req(req), .mute(mute),
    .pitch(pitch_b), .music(music_b), .busy(busy_b),
    .grant(grant_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int s0[8] = '{151515, 151515, 151515, 151515,
                191571, 151515, 127551, 127551};
  int s1[8] = '{191571, 151515, 127551, 95420, 0, 0, 0, 0};
  int s2[8] = '{101215, 143266, 143266, 143266,
                151515, 170648, 191571, 191571};
  int slen[3] = '{8, 4, 8};
  int gapv[2] = '{2, 0};

  int       cur[2];
  int       t[2];
  bit [2:0] pend[2];
  bit       dn[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int note_pitch(input int s, input int i);
    if (s == 2) return s2[i];
    if (s == 1) return s1[i];
    return s0[i];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cur[k]  = -1;
      t[k]    = 0;
      pend[k] = '0;
      dn[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit [2:0] gm;
      bit [2:0] eff;
      int per;
      per = N + gapv[k];
      gm  = (cur[k] >= 0) ? 3'(1 << cur[k]) : 3'b000;
      eff = pend[k] | (req & ~gm);
      dn[k] = 1'b0;
      if (cur[k] < 0) begin
        if (eff != 0) begin
          cur[k] = eff[2] ? 2 : (eff[1] ? 1 : 0);
          eff[cur[k]] = 1'b0;
          t[k] = 0;
        end
      end else if (cur[k] != 2 && eff[2]) begin
        cur[k] = 2;
        eff[2] = 1'b0;
        t[k] = 0;
      end else begin
        t[k]++;
        if (t[k] == slen[cur[k]] * per) begin
          cur[k] = -1;
          dn[k] = 1'b1;
        end
      end
      pend[k] = eff;
    end
  endtask

  task automatic check_one(input int k, input logic [21:0] p,
                           input logic m, input logic b,
                           input logic [2:0] g, input logic d);
    int per;
    int ep, eg;
    bit em, eb;
    per = N + gapv[k];
    if (cur[k] < 0) begin
      ep = 0; eg = 0; em = 0; eb = 0;
    end else begin
      ep = note_pitch(cur[k], t[k] / per);
      eg = 1 << cur[k];
      eb = 1;
      em = ((t[k] % per) < N) && !mute;
    end
    chk($sformatf("pitch%0d", k), 32'(p), 32'(ep));
    chk($sformatf("music%0d", k), 32'(m), 32'(em));
    chk($sformatf("busy%0d", k), 32'(b), 32'(eb));
    chk($sformatf("grant%0d", k), 32'(g), 32'(eg));
    chk($sformatf("done%0d", k), 32'(d), 32'(dn[k]));
  endtask

  task automatic check_all();
    check_one(0, pitch_a, music_a, busy_a, grant_a, done_a);
    check_one(1, pitch_b, music_b, busy_b, grant_b, done_b);
  endtask

  task automatic cyc(input logic [2:0] r, input logic m);
    @(negedge clk);
    rst  = 1'b0;
    req  = r;
    mute = m;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req = 3'b000;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    logic [2:0] r;
    logic       m;
    rst  = 1'b1;
    req  = 3'b000;
    mute = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();

    cyc(3'b010, 1'b0);
    repeat (30) cyc(3'b000, 1'b0);
    cyc(3'b011, 1'b0);
    repeat (65) cyc(3'b000, 1'b0);
    cyc(3'b001, 1'b0);
    repeat (20) cyc(3'b000, 1'b0);
    cyc(3'b100, 1'b0);
    repeat (55) cyc(3'b000, 1'b0);
    cyc(3'b010, 1'b1);
    repeat (30) cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b0);
    repeat (10) cyc(3'b000, 1'b0);
    reset_mid();
    repeat (5) cyc(3'b000, 1'b0);

    m = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 99) == 0) m = ~m;
      if (i % 1000 == 500) reset_mid();
      cyc(r, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/melody_scheduler.md
Name: melody_scheduler

Overview:
Sequences and arbitrates the shared buzzer tone path between three game-event jingles: start, score and gameover. Each jingle is a fixed note table. The block steps through the table with programmable note and gap durations and drives the pitch half-period word and the music enable into the existing tone generator. It sits between the game FSM (event requests) and the tone/buzzer driver.

Parameters:
NOTE_TICKS, 25000000, clk cycles a note sounds (0.25 s at 100 MHz); must be >= 1.
GAP_TICKS, 2500000, silent clk cycles after each note; 0 = no gap (legato).
CNT_W, 25, duration counter width; must hold max(NOTE_TICKS, GAP_TICKS).

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
req  input  3  1-cycle request pulses: bit0 start jingle, bit1 score jingle, bit2 gameover jingle.
mute  input  1  forces music low; sequencing and timing are unaffected.
pitch  output  22  half-period count of the current note; 0 when idle.
music  output  1  tone enable to the buzzer driver.
busy  output  1  high while any jingle is granted.
grant  output  3  one-hot id of the jingle playing; 0 when idle.
done  output  1  1-cycle pulse when a jingle completes normally.

Behaviour:
- Pitch constants (22-bit): do 191571, re 170648, mi 151515, fa 143266, so 127551, la 113636, si 101215, high_do 95420.
- Tables: song0 (start, 8 notes) mi mi mi mi do mi so so; song1 (score, 4 notes) do mi so high_do; song2 (gameover, 8 notes) si fa fa fa mi re do do.
- Pending register pend[2:0]: a req bit sets pend; the bit clears on the cycle its song is granted. A req for the currently granted song is ignored. If a req arrives in the same cycle as the grant of the same song, it is absorbed and does not replay.
- Priority: 2 > 1 > 0.
- FSM states: IDLE, NOTE, GAP.
- IDLE: with pend != 0, the next edge grants the highest-priority pending song, sets index=0 and enters NOTE. pitch, grant and busy update on that edge.
- NOTE: music = ~mute and pitch = table[index]. Lasts exactly NOTE_TICKS cycles. Then:
  - GAP_TICKS > 0: go to GAP.
  - GAP_TICKS = 0: go to the next note, or finish.
- GAP: music = 0 and pitch holds the current note. Lasts GAP_TICKS cycles. Then:
  - more notes remain: index+1, NOTE.
  - last note done: finish.
- Finish: return to IDLE, assert done for 1 cycle, and clear grant, busy and pitch on the same edge. A song still pending is granted on the following edge, so IDLE always spans at least 1 cycle.
- Total song length = N*(NOTE_TICKS+GAP_TICKS) cycles from the first NOTE cycle to the done pulse.
- Preemption: a gameover request (req[2] or pend[2]) while song0 or song1 plays aborts that song. On the next edge: grant=100, index=0, NOTE, counters reload. The aborted song gets no done pulse and is not re-queued. Songs 0 and 1 never preempt each other; they wait in pend.
- Reset (any time, including mid-note): state IDLE, pend=0, index=0, counters=0, pitch=0, music=0, busy=0, grant=0, done=0.
- Outputs are registered. music is low whenever state is not NOTE.

Test Plan:
All scenarios use NOTE_TICKS=4 and GAP_TICKS=2.
- Reset: assert rst mid-run, asynchronously -> pitch=0, music=0, grant=0, busy=0 immediately, and they stay 0 after release with no req.
- req=010 pulse:
  - Next edge: grant=010, pitch=191571, music=1 for 4 cycles, then 0 for 2.
  - Pitch sequence: 191571, 151515, 127551, 95420.
  - done pulses 24 cycles after the first NOTE cycle; grant=0 and pitch=0 on that edge.
- req=011 in the same cycle -> song1 plays fully, done, 1 IDLE cycle, then grant=001 with pitch 151515.
- Song0 playing, index 3, pulse req[2] -> next edge grant=100, pitch=101215, music=1, no done for song0. Gameover completes after 48 cycles with a single done pulse.
- mute=1 during song1 -> music stays 0, while pitch steps and done timing are identical to the unmuted run.
- GAP_TICKS=0, song1 -> music stays 1 continuously for 16 cycles, pitch changing every 4 cycles, then done.
